// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel debouncer for push-buttons and vehicle sensors.
// Each channel synchronises its raw input through two flops, requires the new
// value to persist for STABLE_CYCLES before the debounced level follows, and
// emits one-cycle rise/fall pulses plus a single long-press held pulse.
//
// Ports:
//   clk    in   1         system clock, rising edge
//   rst_n  in   1         synchronous active-low reset
//   in_raw in   CHANNELS  asynchronous raw inputs
//   level  out  CHANNELS  debounced level
//   rise   out  CHANNELS  one-cycle pulse on debounced 0->1
//   fall   out  CHANNELS  one-cycle pulse on debounced 1->0
//   held   out  CHANNELS  one-cycle pulse once level has been 1 for HOLD_CYCLES
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_TERM = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(HOLD_CYCLES - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic              r_s1;
    logic              r_s2;
    logic [STAB_W-1:0] r_stab;
    logic [HOLD_W-1:0] r_hold;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;
    logic              r_held;

    // Synchroniser, stability filter, edge pulses and saturating hold counter.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_stab  <= '0;
        r_hold  <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_s1   <= in_raw[i];
        r_s2   <= r_s1;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_held <= 1'b0;

        // Any agreement with the current level discards a partial count.
        if (r_s2 == r_level) begin
          r_stab <= '0;
        end else if (r_stab == STAB_TERM) begin
          r_level <= r_s2;
          r_stab  <= '0;
          r_rise  <= r_s2;
          r_fall  <= ~r_s2;
        end else begin
          r_stab <= r_stab + STAB_W'(1);
        end

        // Uses the pre-edge level, so the edge that raises level is not counted.
        if (!r_level) begin
          r_hold <= '0;
        end else if (r_hold < HOLD_MAX) begin
          r_hold <= r_hold + HOLD_W'(1);
          if (r_hold == HOLD_PRE) r_held <= 1'b1;
        end
      end
    end

    assign level[i] = r_level;
    assign rise[i]  = r_rise;
    assign fall[i]  = r_fall;
    assign held[i]  = r_held;
  end

endmodule
